// File: rtl/aoc_ascii_pkg.sv
// Shared ASCII constants and parser state encoding for the AOC number-input converter.
package aoc_ascii_pkg;

  localparam logic [7:0] CHAR_ZERO     = 8'h30;
  // Newline (8'h0A) after the '0' offset has been subtracted.
  localparam logic [7:0] NL_MINUS_ZERO = 8'hDA;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic is_digit(input logic [7:0] offset);
    return (offset <= 8'd9);
  endfunction

endpackage

// File: rtl/decimal_mac.sv
// Combinational decimal multiply-accumulate: acc*10 + digit with carry-out detection.
module decimal_mac #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [3:0]       digit_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  // Four extra bits hold the largest possible 10*acc + 9 without loss.
  logic [WIDTH+3:0] wide_s;

  assign wide_s  = ({4'b0000, acc_i} << 3) + ({4'b0000, acc_i} << 1) + {{WIDTH{1'b0}}, digit_i};
  assign sum_o   = wide_s[WIDTH-1:0];
  assign carry_o = |wide_s[WIDTH+3:WIDTH];

endmodule

// File: rtl/decimal_line_accumulator.sv
// Parses ASCII decimal lines into binary numbers and hands each one off over valid/ready.
module decimal_line_accumulator
  import aoc_ascii_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_overflow,
  output logic             out_last
);

  localparam int            CW      = $clog2(MAX_DIGITS + 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             mac_carry_s;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_value_q;
  logic             out_overflow_q;
  logic             out_last_q;
  logic [7:0]       d_s;
  logic             accept_s;
  logic             is_digit_s;
  logic             is_nl_s;
  logic             pending_s;
  logic             emit_s;

  assign d_s        = in_data - CHAR_ZERO;
  assign is_digit_s = is_digit(d_s);
  assign is_nl_s    = (d_s == NL_MINUS_ZERO);
  assign accept_s   = in_valid & in_ready_q;
  // A final byte of any kind flushes a number that already has digits.
  assign pending_s  = is_digit_s | (state_q == ACCUM);
  assign emit_s     = (is_nl_s | in_last) & pending_s;

  decimal_mac #(.WIDTH(WIDTH)) u_mac (
    .acc_i   (acc_q),
    .digit_i (d_s[3:0]),
    .sum_o   (acc_d),
    .carry_o (mac_carry_s)
  );

  // Count saturates one past the limit so the overflow flag stays meaningful.
  assign cnt_d = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + CW'(1);
  assign ovf_d = ovf_q | mac_carry_s | (cnt_d > CNT_MAX);

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_value    = out_value_q;
  assign out_overflow = out_overflow_q;
  assign out_last     = out_last_q;

  // Parser FSM with accumulator, digit count, sticky overflow and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      acc_q          <= {WIDTH{1'b0}};
      cnt_q          <= {CW{1'b0}};
      ovf_q          <= 1'b0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_value_q    <= {WIDTH{1'b0}};
      out_overflow_q <= 1'b0;
      out_last_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept_s) begin
            if (is_digit_s) begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
              ovf_q <= ovf_d;
            end
            if (emit_s) begin
              out_valid_q    <= 1'b1;
              out_value_q    <= is_digit_s ? acc_d : acc_q;
              out_overflow_q <= is_digit_s ? ovf_d : ovf_q;
              out_last_q     <= in_last;
              in_ready_q     <= 1'b0;
              state_q        <= EMIT;
            end else if (in_last) begin
              in_ready_q <= 1'b0;
              state_q    <= DONE;
            end else if (is_digit_s) begin
              state_q <= ACCUM;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q    <= 1'b0;
            out_value_q    <= {WIDTH{1'b0}};
            out_overflow_q <= 1'b0;
            out_last_q     <= 1'b0;
            acc_q          <= {WIDTH{1'b0}};
            cnt_q          <= {CW{1'b0}};
            ovf_q          <= 1'b0;
            in_ready_q     <= ~out_last_q;
            state_q        <= out_last_q ? DONE : IDLE;
          end
        end
        DONE: begin
          in_ready_q <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
